// File: rtl/count_stim_pkg.sv
// count_stim_pkg: shared types and constants for the count_stim_driver slice.
//   state_e        driver FSM states
//   CNT_LO/CNT_HI  bounds of the squaring band of the out-mapping
//   POW_EXP        exponent applied inside the band (square)
//   DIV_BY         divisor applied above the band (implemented as a shift)
package count_stim_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_e;

    localparam logic [7:0] CNT_LO  = 8'h04;
    localparam logic [7:0] CNT_HI  = 8'h10;
    localparam int         POW_EXP = 2;
    localparam int         DIV_BY  = 2;

    // Shift amount equivalent to dividing by DIV_BY (DIV_BY is a power of two).
    localparam int DIV_SHIFT = $clog2(DIV_BY);

endpackage

// File: rtl/count_stim_driver_if.sv
// count_stim_driver_if: request handshake between a requester and the driver.
//   req_valid  requester -> driver   request valid
//   req_count  requester -> driver   number of increment cycles
//   req_ready  driver -> requester   driver can accept (IDLE only)
interface count_stim_driver_if #(
    parameter int W = 8
);
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_count;

    modport master (
        output req_valid,
        output req_count,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_count,
        output req_ready
    );
endinterface

// File: rtl/cnt_out_model.sv
// cnt_out_model: combinational out-mapping of the zero-counting counter.
//   c  in   W   counter value
//   f  out  W   mapped value: c<4 -> 0; 4..16 -> c*c mod 2^W; c>16 -> c/2
module cnt_out_model
    import count_stim_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] c,
    output logic [W-1:0] f
);

    logic [2*W-1:0] sq_s;

    // Full-width square; only the low W bits are kept (c=16 wraps to 0).
    always_comb begin
        sq_s = {{W{1'b0}}, c} * {{W{1'b0}}, c};
    end

    // Band selection of the mapping.
    always_comb begin
        if (c < W'(CNT_LO)) begin
            f = '0;
        end else if (c <= W'(CNT_HI)) begin
            f = sq_s[W-1:0];
        end else begin
            f = c >> DIV_SHIFT;
        end
    end

endmodule

// File: rtl/count_stim_driver.sv
// count_stim_driver: drives a zero-counting counter's 'in' line low for a
// requested number of cycles, waits for its output to settle and compares the
// observed output against a shadow model.
//   clk, reset   clock and synchronous active-high reset
//   req          request handshake (slave side): req_valid/req_count/req_ready
//   drv_in       to counter 'in' (0 = increment, 1 = hold), registered
//   obs_out      counter 'out'
//   busy         high whenever not IDLE
//   done         one-cycle pulse when a check completes
//   match        obs_out == exp_out, valid with done
//   exp_out      expected counter output, held until the next done
//   model_cnt    shadow counter value (cumulative across requests)
module count_stim_driver
    import count_stim_pkg::*;
#(
    parameter int W             = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    count_stim_driver_if.slave  req,
    output logic                drv_in,
    input  logic [W-1:0]        obs_out,
    output logic                busy,
    output logic                done,
    output logic                match,
    output logic [W-1:0]        exp_out,
    output logic [W-1:0]        model_cnt
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    state_e         state_q, state_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [SW-1:0]  scnt_q, scnt_d;
    logic [W-1:0]   model_q, model_d;
    logic           drv_q, drv_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           match_q, match_d;
    logic [W-1:0]   exp_q, exp_d;
    logic [W-1:0]   f_s;

    cnt_out_model #(.W(W)) u_model (
        .c (model_q),
        .f (f_s)
    );

    // Next-state and next-output logic; all outputs are registered from *_d.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        scnt_d  = scnt_q;
        model_d = model_q;
        drv_d   = 1'b1;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        match_d = match_q;
        exp_d   = exp_q;
        case (state_q)
            IDLE: begin
                if (req.req_valid && ready_q) begin
                    rem_d  = req.req_count;
                    scnt_d = '0;
                    if (req.req_count != '0) begin
                        state_d = DRIVE;
                        drv_d   = 1'b0;
                    end else begin
                        // Zero-length request still goes through settle/check.
                        state_d = SETTLE;
                        drv_d   = 1'b1;
                    end
                end else begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            DRIVE: begin
                model_d = model_q + W'(1);
                rem_d   = rem_q - W'(1);
                if (rem_q == W'(1)) begin
                    state_d = SETTLE;
                    drv_d   = 1'b1;
                end else begin
                    drv_d   = 1'b0;
                end
            end
            SETTLE: begin
                // Covers the counter's count register plus its output register.
                if (scnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = CHECK;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            CHECK: begin
                exp_d   = f_s;
                match_d = (obs_out == f_s);
                done_d  = 1'b1;
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            scnt_q  <= '0;
            model_q <= '0;
            drv_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            scnt_q  <= scnt_d;
            model_q <= model_d;
            drv_q   <= drv_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            match_q <= match_d;
            exp_q   <= exp_d;
        end
    end

    assign req.req_ready = ready_q;
    assign drv_in        = drv_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign match         = match_q;
    assign exp_out       = exp_q;
    assign model_cnt     = model_q;

endmodule
